// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, start bit, 8 data bits LSB-first, odd parity,
// released stop bit, then device ACK check. Drives the pads open-drain through *_drive_low.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int FILTER_CYCLES  = 16,
    parameter int START_TIMEOUT  = 750000,
    parameter int XFER_TIMEOUT   = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    output logic [1:0] tx_err_code,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low
);

    localparam int CNT_MAX_A = (START_TIMEOUT > XFER_TIMEOUT) ? START_TIMEOUT : XFER_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > INHIBIT_CYCLES) ? CNT_MAX_A : INHIBIT_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int FLT_W     = $clog2(FILTER_CYCLES + 1);

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] XFER_LAST    = CNT_W'(XFER_TIMEOUT - 1);
    localparam logic [FLT_W-1:0] FILTER_LAST  = FLT_W'(FILTER_CYCLES - 1);

    localparam logic [1:0] ERR_START = 2'b01;
    localparam logic [1:0] ERR_XFER  = 2'b10;
    localparam logic [1:0] ERR_NOACK = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_RELEASE, S_WAIT_FIRST, S_SHIFT, S_WAIT_IDLE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [9:0]        shift_q, shift_d;
    logic              clk_dl_q, clk_dl_d;
    logic              data_dl_q, data_dl_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
    logic              clk_flt_q, clk_flt_d;
    logic [FLT_W-1:0]  flt_cnt_q, flt_cnt_d;
    logic              fall_q, fall_d;
    logic              accept, abort, xfer_timeout;
    logic [1:0]        abort_code;

    // A ps2_clk level change is taken only after FILTER_CYCLES consecutive differing samples.
    always_comb begin
        clk_flt_d = clk_flt_q;
        flt_cnt_d = '0;
        if (clk_sync_q != clk_flt_q) begin
            if (flt_cnt_q == FILTER_LAST) begin
                clk_flt_d = clk_sync_q;
            end else begin
                flt_cnt_d = flt_cnt_q + 1'b1;
            end
        end
        fall_d = clk_flt_q & ~clk_flt_d;
    end

    assign accept = tx_valid & tx_ready;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        clk_dl_d     = clk_dl_q;
        data_dl_d    = data_dl_q;
        done_d       = 1'b0;
        error_d      = 1'b0;
        err_code_d   = err_code_q;
        abort        = 1'b0;
        abort_code   = 2'b00;
        xfer_timeout = (cnt_q == XFER_LAST);
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d    = S_INHIBIT;
                    cnt_d      = '0;
                    bit_cnt_d  = '0;
                    clk_dl_d   = 1'b1;
                    data_dl_d  = 1'b0;
                    shift_d    = {1'b1, ~^tx_data, tx_data};
                    err_code_d = 2'b00;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == INHIBIT_LAST) begin
                    data_dl_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RELEASE: begin
                clk_dl_d = 1'b0;
                cnt_d    = '0;
                state_d  = S_WAIT_FIRST;
            end
            S_WAIT_FIRST: begin
                // Timeout is checked first so it wins over a coincident falling edge.
                if (cnt_q == START_LAST) begin
                    abort      = 1'b1;
                    abort_code = ERR_START;
                end else if (fall_q) begin
                    data_dl_d = ~shift_q[0];
                    shift_d   = {1'b1, shift_q[9:1]};
                    bit_cnt_d = 4'd1;
                    cnt_d     = '0;
                    state_d   = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SHIFT: begin
                if (xfer_timeout) begin
                    abort      = 1'b1;
                    abort_code = ERR_XFER;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (fall_q) begin
                        if (bit_cnt_q < 4'd10) begin
                            data_dl_d = ~shift_q[0];
                            shift_d   = {1'b1, shift_q[9:1]};
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end else if (!data_sync_q) begin
                            state_d = S_WAIT_IDLE;
                        end else begin
                            abort      = 1'b1;
                            abort_code = ERR_NOACK;
                        end
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (xfer_timeout) begin
                    abort      = 1'b1;
                    abort_code = ERR_XFER;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (clk_flt_q && data_sync_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            clk_dl_d   = 1'b0;
            data_dl_d  = 1'b0;
            error_d    = 1'b1;
            err_code_d = abort_code;
            state_d    = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        clk_meta_q  <= ps2_clk_i;
        clk_sync_q  <= clk_meta_q;
        data_meta_q <= ps2_data_i;
        data_sync_q <= data_meta_q;
        shift_q     <= shift_d;
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            clk_dl_q   <= 1'b0;
            data_dl_q  <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= 2'b00;
            clk_flt_q  <= 1'b1;
            flt_cnt_q  <= '0;
            fall_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            clk_dl_q   <= clk_dl_d;
            data_dl_q  <= data_dl_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
            clk_flt_q  <= clk_flt_d;
            flt_cnt_q  <= flt_cnt_d;
            fall_q     <= fall_d;
        end
    end

    // Ready is held off during the done/error pulse so it returns the cycle after.
    assign tx_ready           = (state_q == S_IDLE) && !done_q && !error_q;
    assign busy               = (state_q != S_IDLE);
    assign tx_done            = done_q;
    assign tx_error           = error_q;
    assign tx_err_code        = err_code_q;
    assign ps2_clk_drive_low  = clk_dl_q;
    assign ps2_data_drive_low = data_dl_q;

endmodule
